// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin owner of a shared tristate bus with a one-cycle
// turnaround gap and a hold limit; all outputs are registered.
module rr_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N-1:0]         i_req,
    input  logic                 i_done,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_gnt_id,
    output logic                 o_busy,
    output logic                 o_timeout
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t          r_state, w_state;
    logic [IW-1:0]   r_ptr, w_ptr, r_owner, w_owner, w_win;
    logic [HW-1:0]   r_hcnt, w_hcnt;
    logic [N-1:0]    w_gnt;
    logic            w_timeout, w_limit, w_release;

    // Lowest offset from the pointer wins, so scan offsets high to low.
    always_comb begin
        w_win = '0;
        for (int i = N - 1; i >= 0; i--)
            if (i_req[(int'(r_ptr) + i) % N]) w_win = IW'((int'(r_ptr) + i) % N);
    end

    assign w_limit   = r_hcnt == HW'(MAX_HOLD - 1);
    assign w_release = i_done || !i_req[r_owner] || w_limit;

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_owner   = r_owner;
        w_hcnt    = r_hcnt;
        w_gnt     = '0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE, GAP: begin
                w_state = IDLE;
                if (|i_req) begin
                    w_state = OWN;
                    w_owner = w_win;
                    w_hcnt  = '0;
                    w_gnt   = N'(1) << w_win;
                end
            end
            OWN: begin
                if (w_release) begin
                    w_state   = GAP;
                    w_ptr     = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;
                    w_timeout = !i_done && i_req[r_owner];
                end else begin
                    w_hcnt = r_hcnt + 1'b1;
                    w_gnt  = N'(1) << r_owner;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_hcnt    <= '0;
            o_gnt     <= '0;
            o_gnt_id  <= '0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_owner   <= w_owner;
            r_hcnt    <= w_hcnt;
            o_gnt     <= w_gnt;
            o_gnt_id  <= (w_state == OWN) ? w_owner : '0;
            o_busy    <= |w_gnt;
            o_timeout <= w_timeout;
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed scenarios with per-cycle expectations queued at
// drive time and popped after the following clock edge.
module tb_rr_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       done = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] o_gnt;
    logic [1:0] o_gnt_id;
    logic       o_busy, o_timeout;

    typedef struct packed {logic [3:0] gnt; logic to;} exp_t;
    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_done(done),
        .o_gnt(o_gnt), .o_gnt_id(o_gnt_id), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        return g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
    endfunction

    task automatic cyc(input logic [3:0] r, input logic d, input logic [3:0] eg, input logic et);
        exp_t e;
        req  = r;
        done = d;
        q.push_back({eg, et});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("gnt", 32'(o_gnt), 32'(e.gnt));
        chk("gnt_id", 32'(o_gnt_id), 32'(idx_of(e.gnt)));
        chk("busy", 32'(o_busy), 32'(|e.gnt));
        chk("timeout", 32'(o_timeout), 32'(e.to));
        chk("onehot", 32'($onehot0(o_gnt)), 32'd1);
    endtask

    initial begin
        req = 4'b1111;
        #12;
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b1111, 1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b1111, 1'b0, 4'(1 << i), 1'b0);
            cyc(4'b1111, 1'b1, 4'b0000, 1'b0);
            cyc(4'b1111, 1'b0, 4'(1 << ((i + 1) % 4)), 1'b0);
        end
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
        // Hold limit: 8 owned cycles, timeout in the gap, then regrant.
        cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
        for (int k = 0; k < 7; k++) cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
        cyc(4'b0100, 1'b0, 4'b0000, 1'b1);
        cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
        // DONE on the 8th owned cycle is a normal release.
        for (int k = 0; k < 7; k++) cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
        cyc(4'b0100, 1'b1, 4'b0000, 1'b0);
        // Pointer now 3: REQ=0011 wraps to 0, then 1.
        cyc(4'b0011, 1'b0, 4'b0001, 1'b0);
        cyc(4'b0011, 1'b1, 4'b0000, 1'b0);
        cyc(4'b0011, 1'b0, 4'b0010, 1'b0);
        cyc(4'b0011, 1'b0, 4'b0010, 1'b0);
        cyc(4'b0011, 1'b0, 4'b0010, 1'b0);
        cyc(4'b0001, 1'b0, 4'b0000, 1'b0);
        // Pointer advanced past 1, so 0 wins over 1.
        cyc(4'b0011, 1'b0, 4'b0001, 1'b0);
        cyc(4'b0010, 1'b1, 4'b0000, 1'b0);
        cyc(4'b0010, 1'b0, 4'b0010, 1'b0);
        // Asynchronous reset between edges while owner 1 holds the bus.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(o_gnt), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_id", 32'(o_gnt_id), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_gnt", 32'(o_gnt), 32'd0);
        rst_n = 1'b1;
        cyc(4'b0010, 1'b0, 4'b0010, 1'b0);
        cyc(4'b0010, 1'b1, 4'b0000, 1'b0);
        // Pointer back at 2 after owner 1: REQ=0101 picks 2 before 0.
        cyc(4'b0101, 1'b0, 4'b0100, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
